ysyx_23060025_axi_sram_slave: RTL and testbench
===============================================

Name: ysyx_23060025_axi_sram_slave

Overview:
- AXI4-Lite-style responder (slave) for the LSU/IFU master ports: AR/R, AW/W and B channels, 32-bit data.
- Backs a word-addressed on-chip memory with configurable read/write latency, so the master-side handshakes can be exercised with real stalls.
- Single outstanding transaction. Read and write share one port with fair arbitration. Out-of-range or oversize accesses return SLVERR.

Parameters:
- DATA_LEN, 32, data width; only 32 is supported.
- ADDR_LEN, 32, address width.
- MEM_DEPTH, 1024, number of 32-bit words; power of two.
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- RD_LATENCY, 1, extra wait cycles between AR handshake and r_valid_o (0..15).
- WR_LATENCY, 1, extra wait cycles between AW+W capture and bkwd_valid_o (0..15).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- addr_r_addr_i  in  ADDR_LEN  read address
- addr_r_size_i  in  3  read size: 0 = 1B, 1 = 2B, 2 = 4B
- addr_r_valid_i  in  1  read address valid
- addr_r_ready_o  out  1  read address accepted
- r_data_o  out  DATA_LEN  read data; always the full aligned word
- r_resp_o  out  2  2'b00 OKAY, 2'b10 SLVERR
- r_valid_o  out  1  read data valid
- r_ready_i  in  1  master ready for read data
- addr_w_addr_i  in  ADDR_LEN  write address
- addr_w_size_i  in  3  write size
- addr_w_valid_i  in  1  write address valid
- addr_w_ready_o  out  1  write address accepted
- w_data_i  in  DATA_LEN  write data, lane-positioned by the master
- w_strb_i  in  4  byte strobes
- w_valid_i  in  1  write data valid
- w_ready_o  out  1  write data accepted
- bkwd_resp_o  out  2  write response
- bkwd_valid_o  out  1  write response valid
- bkwd_ready_i  in  1  master ready for write response

Behaviour:
- Reset values:
  - All ready and valid outputs 0; r_data_o = 0; r_resp_o = 0; bkwd_resp_o = 0.
  - State = IDLE; grant pointer favours read.
  - Memory contents are not reset.
- States: IDLE, R_WAIT, R_RESP, W_COLLECT, W_WAIT, B_RESP.
- IDLE arbitration:
  - Read request = addr_r_valid_i. Write request = addr_w_valid_i | w_valid_i.
  - Only one request present: grant it.
  - Both present: grant the side not granted last. The pointer toggles only on a granted transaction.
- Ready outputs are combinational (ready may depend on valid):
  - addr_r_ready_o = IDLE & read granted.
  - addr_w_ready_o = (IDLE & write granted) | (W_COLLECT & AW not yet captured).
  - w_ready_o = (IDLE & write granted) | (W_COLLECT & W not yet captured).
- Read path:
  - On AR handshake: latch address, check it, load latency counter with RD_LATENCY, go to R_WAIT.
  - R_WAIT decrements the counter. When the counter is 0, read the array, register data and response, go to R_RESP.
  - Result: r_valid_o first high exactly RD_LATENCY + 1 cycles after the handshake edge.
  - R_RESP: r_valid_o = 1; r_data_o and r_resp_o held stable until r_ready_i. The cycle after the handshake, the block is back in IDLE.
- Write path:
  - AW and W are captured independently into holding registers.
  - If both arrive in the IDLE grant cycle (the LSU case), go straight to W_WAIT. Otherwise go to W_COLLECT until the missing one arrives.
  - Entering W_WAIT: load counter with WR_LATENCY.
  - At count 0: commit bytes where w_strb_i bit i = 1, byte i = data[8i+7:8i]; go to B_RESP.
  - B_RESP: bkwd_valid_o = 1 with response held until bkwd_ready_i, then IDLE.
- Error check, per transaction:
  - addr < BASE_ADDR, addr ≥ BASE_ADDR + 4·MEM_DEPTH, or size > 2 → resp 2'b10.
  - Error read returns data 0. Error write leaves memory unchanged. Latency is identical to a good access.
- Index = (addr - BASE_ADDR)[log2(MEM_DEPTH)+1:2]. Low address bits are ignored for data; lane selection is the master's job.
- Strobe 4'b0000 on a write: memory unchanged, resp OKAY.
- Valid deasserted by the master before its handshake: the request is dropped and not latched.
- Reset mid-transaction: abort; all outputs return to reset values the next cycle; a partial write commits nothing.

Decomposition:
- Shared package or define file:
  - Response codes: AXI_RESP_OKAY = 2'b00, AXI_RESP_SLVERR = 2'b10.
  - AXI size encodings (same values the LSU drives).
  - State encodings for this block.
- Sub-module ysyx_23060025_sram_array:
  - Synchronous write with 4-bit byte enables; combinational read; MEM_DEPTH × 32.
  - Keeps the storage separate from the protocol FSM.

Test Plan:
- AW and W same cycle, addr 0x8000_0010, data 0xDEADBEEF, strb 4'hF; then AR 0x8000_0010 → B resp 00; r_data_o = 0xDEADBEEF, resp 00; with RD_LATENCY = 1, r_valid_o rises 2 cycles after the AR handshake.
- Preload 0x11223344, then write strb 4'b0100 data 0x00AA0000 → readback 0x11AA3344.
- AR 0x7FFF_FFFC and AW 0x8000_1000 (MEM_DEPTH = 1024) → resp 2'b10, r_data_o = 0, memory unchanged.
- AR valid and AW+W valid in the same cycle, twice in a row → first grant read, next grant write, then alternate.
- Hold r_ready_i low 5 cycles after r_valid_o → data and resp stable, addr_r_ready_o stays 0 throughout.
- W valid alone, AW 3 cycles later → w_ready_o pulses on the W cycle, the block stays in W_COLLECT, and the commit happens only after AW. Separately: assert reset during W_WAIT → no memory change, bkwd_valid_o = 0.

Source files
------------

// File: rtl/ysyx_23060025_axi_sram_slave_pkg.sv
// Shared AXI response/size codes and FSM state encoding for the SRAM responder.
// Pure declarations; no latency or flow-control behaviour of its own.
package ysyx_23060025_axi_sram_slave_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam logic [2:0] AXI_SIZE_1B = 3'd0;
  localparam logic [2:0] AXI_SIZE_2B = 3'd1;
  localparam logic [2:0] AXI_SIZE_4B = 3'd2;

  localparam int LAT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_R_WAIT,
    ST_R_RESP,
    ST_W_COLLECT,
    ST_W_WAIT,
    ST_B_RESP
  } state_t;

  function automatic logic size_legal(input logic [2:0] size);
    return size inside {AXI_SIZE_1B, AXI_SIZE_2B, AXI_SIZE_4B};
  endfunction

endpackage

// File: rtl/ysyx_23060025_axi_sram_slave_if.sv
// AR/R, AW/W and B channel bundle between an LSU/IFU master and the SRAM responder.
// Wires only; all timing and backpressure live in the endpoints.
interface ysyx_23060025_axi_sram_slave_if #(
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 32
);
  logic [ADDR_LEN-1:0] addr_r_addr_i;
  logic [2:0]          addr_r_size_i;
  logic                addr_r_valid_i;
  logic                addr_r_ready_o;
  logic [DATA_LEN-1:0] r_data_o;
  logic [1:0]          r_resp_o;
  logic                r_valid_o;
  logic                r_ready_i;
  logic [ADDR_LEN-1:0] addr_w_addr_i;
  logic [2:0]          addr_w_size_i;
  logic                addr_w_valid_i;
  logic                addr_w_ready_o;
  logic [DATA_LEN-1:0] w_data_i;
  logic [3:0]          w_strb_i;
  logic                w_valid_i;
  logic                w_ready_o;
  logic [1:0]          bkwd_resp_o;
  logic                bkwd_valid_o;
  logic                bkwd_ready_i;

  modport slave (
    input  addr_r_addr_i, addr_r_size_i, addr_r_valid_i, r_ready_i,
    input  addr_w_addr_i, addr_w_size_i, addr_w_valid_i,
    input  w_data_i, w_strb_i, w_valid_i, bkwd_ready_i,
    output addr_r_ready_o, r_data_o, r_resp_o, r_valid_o,
    output addr_w_ready_o, w_ready_o, bkwd_resp_o, bkwd_valid_o
  );

  modport master (
    output addr_r_addr_i, addr_r_size_i, addr_r_valid_i, r_ready_i,
    output addr_w_addr_i, addr_w_size_i, addr_w_valid_i,
    output w_data_i, w_strb_i, w_valid_i, bkwd_ready_i,
    input  addr_r_ready_o, r_data_o, r_resp_o, r_valid_o,
    input  addr_w_ready_o, w_ready_o, bkwd_resp_o, bkwd_valid_o
  );
endinterface

// File: rtl/ysyx_23060025_sram_array.sv
// Word-wide storage with per-byte write enables: write lands on the clock edge,
// read is combinational from rd_idx; no flow control, contents are never reset.
module ysyx_23060025_sram_array #(
  parameter int DEPTH    = 1024,
  parameter int DATA_LEN = 32,
  localparam int IDX_W   = $clog2(DEPTH),
  localparam int STRB_W  = DATA_LEN / 8
) (
  input  logic                clock,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [DATA_LEN-1:0] wr_data,
  input  logic [STRB_W-1:0]   wr_strb,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic [DATA_LEN-1:0] rd_data
);
  logic [DATA_LEN-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wr_strb[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  assign rd_data = mem[rd_idx];
endmodule

// File: rtl/ysyx_23060025_axi_sram_slave.sv
// AXI4-Lite-style SRAM responder, one transaction at a time; R/B valid after LATENCY+1 cycles.
// Readies are combinational in IDLE/W_COLLECT only; R and B responses hold until the master is ready.
module ysyx_23060025_axi_sram_slave
  import ysyx_23060025_axi_sram_slave_pkg::*;
#(
  parameter int                  DATA_LEN   = 32,
  parameter int                  ADDR_LEN   = 32,
  parameter int                  MEM_DEPTH  = 1024,
  parameter logic [ADDR_LEN-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int                  RD_LATENCY = 1,
  parameter int                  WR_LATENCY = 1
) (
  input logic                       clock,
  input logic                       reset,
  ysyx_23060025_axi_sram_slave_if.slave bus
);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [ADDR_LEN:0] MEM_BYTES = (ADDR_LEN + 1)'(4 * MEM_DEPTH);

  // One extra bit on the offset catches addresses below BASE_ADDR as a borrow.
  function automatic logic acc_err(input logic [ADDR_LEN-1:0] addr, input logic [2:0] size);
    logic [ADDR_LEN:0] off;
    off = {1'b0, addr} - {1'b0, BASE_ADDR};
    return off[ADDR_LEN] || (off >= MEM_BYTES) || !size_legal(size);
  endfunction

  function automatic logic [IDX_W-1:0] mem_idx(input logic [ADDR_LEN-1:0] addr);
    logic [ADDR_LEN-1:0] off;
    off = addr - BASE_ADDR;
    return IDX_W'(off >> 2);
  endfunction

  state_t              state_q, state_d;
  logic [LAT_W-1:0]    cnt_q, cnt_d;
  logic                last_wr_q;
  logic [ADDR_LEN-1:0] raddr_q, waddr_q;
  logic [2:0]          rsize_q, wsize_q;
  logic [DATA_LEN-1:0] wdata_q, rdata_q;
  logic [3:0]          wstrb_q;
  logic                aw_got_q, w_got_q;
  logic [1:0]          rresp_q, bresp_q;

  logic rd_req, wr_req, grant_rd, grant_wr, in_idle, in_collect;
  logic ar_hs, aw_hs, w_hs, rd_err, wr_err, mem_we;
  logic [DATA_LEN-1:0] arr_rdata;

  assign rd_req   = bus.addr_r_valid_i;
  assign wr_req   = bus.addr_w_valid_i | bus.w_valid_i;
  // last_wr_q resets high so the first contested grant goes to the read side.
  assign grant_rd = rd_req & (~wr_req | last_wr_q);
  assign grant_wr = wr_req & ~grant_rd;

  assign in_idle    = (state_q == ST_IDLE) & ~reset;
  assign in_collect = (state_q == ST_W_COLLECT) & ~reset;

  assign bus.addr_r_ready_o = in_idle & grant_rd;
  assign bus.addr_w_ready_o = (in_idle & grant_wr) | (in_collect & ~aw_got_q);
  assign bus.w_ready_o      = (in_idle & grant_wr) | (in_collect & ~w_got_q);

  assign ar_hs = bus.addr_r_valid_i & bus.addr_r_ready_o;
  assign aw_hs = bus.addr_w_valid_i & bus.addr_w_ready_o;
  assign w_hs  = bus.w_valid_i & bus.w_ready_o;

  assign rd_err = acc_err(raddr_q, rsize_q);
  assign wr_err = acc_err(waddr_q, wsize_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ar_hs) begin
          state_d = ST_R_WAIT;
          cnt_d   = LAT_W'(RD_LATENCY);
        end else if (aw_hs && w_hs) begin
          state_d = ST_W_WAIT;
          cnt_d   = LAT_W'(WR_LATENCY);
        end else if (aw_hs || w_hs) begin
          state_d = ST_W_COLLECT;
        end
      end
      ST_R_WAIT: begin
        if (cnt_q == '0) state_d = ST_R_RESP;
        else             cnt_d   = cnt_q - LAT_W'(1);
      end
      ST_R_RESP: begin
        if (bus.r_ready_i) state_d = ST_IDLE;
      end
      ST_W_COLLECT: begin
        if ((aw_got_q || aw_hs) && (w_got_q || w_hs)) begin
          state_d = ST_W_WAIT;
          cnt_d   = LAT_W'(WR_LATENCY);
        end
      end
      ST_W_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_B_RESP;
          mem_we  = ~wr_err & ~reset;
        end else begin
          cnt_d = cnt_q - LAT_W'(1);
        end
      end
      ST_B_RESP: begin
        if (bus.bkwd_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      last_wr_q <= 1'b1;
      raddr_q   <= '0;
      rsize_q   <= '0;
      waddr_q   <= '0;
      wsize_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= AXI_RESP_OKAY;
      bresp_q   <= AXI_RESP_OKAY;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (ar_hs) begin
        raddr_q   <= bus.addr_r_addr_i;
        rsize_q   <= bus.addr_r_size_i;
        last_wr_q <= 1'b0;
      end else if (in_idle && grant_wr) begin
        last_wr_q <= 1'b1;
      end
      if (aw_hs) begin
        waddr_q  <= bus.addr_w_addr_i;
        wsize_q  <= bus.addr_w_size_i;
        aw_got_q <= 1'b1;
      end
      if (w_hs) begin
        wdata_q <= bus.w_data_i;
        wstrb_q <= bus.w_strb_i;
        w_got_q <= 1'b1;
      end
      if (state_q == ST_R_WAIT && cnt_q == '0) begin
        rdata_q <= rd_err ? '0 : arr_rdata;
        rresp_q <= rd_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      end
      if (state_q == ST_W_WAIT && cnt_q == '0) begin
        aw_got_q <= 1'b0;
        w_got_q  <= 1'b0;
        bresp_q  <= wr_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      end
    end
  end

  assign bus.r_data_o     = rdata_q;
  assign bus.r_resp_o     = rresp_q;
  assign bus.r_valid_o    = (state_q == ST_R_RESP);
  assign bus.bkwd_resp_o  = bresp_q;
  assign bus.bkwd_valid_o = (state_q == ST_B_RESP);

  ysyx_23060025_sram_array #(
    .DEPTH    (MEM_DEPTH),
    .DATA_LEN (DATA_LEN)
  ) u_array (
    .clock   (clock),
    .wr_en   (mem_we),
    .wr_idx  (mem_idx(waddr_q)),
    .wr_data (wdata_q),
    .wr_strb (wstrb_q),
    .rd_idx  (mem_idx(raddr_q)),
    .rd_data (arr_rdata)
  );
endmodule

// File: tb/tb_ysyx_23060025_axi_sram_slave.sv
// Bench for the SRAM responder: vector table with response scoreboards, then
// hand-written arbitration, stall, split-write and reset-abort sequences.
module tb_ysyx_23060025_axi_sram_slave;
  localparam int RD_LAT = 1;
  localparam int WR_LAT = 1;
  localparam int BUDGET = 60;
  localparam int NVEC   = 18;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  ysyx_23060025_axi_sram_slave_if bus ();

  ysyx_23060025_axi_sram_slave #(
    .DATA_LEN(32), .ADDR_LEN(32), .MEM_DEPTH(1024), .BASE_ADDR(32'h8000_0000),
    .RD_LATENCY(RD_LAT), .WR_LATENCY(WR_LAT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  typedef struct { logic [31:0] data; logic [1:0] resp; } rexp_t;
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  rexp_t      rq[$];
  logic [1:0] bq[$];
  vec_t       vecs[NVEC];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic note_fail(input string name, input string what);
    checks++;
    failures++;
    $display("FAIL %s: %s", name, what);
  endtask

  task automatic idle_inputs();
    bus.addr_r_addr_i  = '0; bus.addr_r_size_i = 3'd2; bus.addr_r_valid_i = 1'b0;
    bus.addr_w_addr_i  = '0; bus.addr_w_size_i = 3'd2; bus.addr_w_valid_i = 1'b0;
    bus.w_data_i       = '0; bus.w_strb_i = 4'h0; bus.w_valid_i = 1'b0;
    bus.r_ready_i      = 1'b1;
    bus.bkwd_ready_i   = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [2:0] size, input string name);
    int t;
    int lat;
    rexp_t e;
    @(negedge clock);
    bus.addr_r_addr_i = addr; bus.addr_r_size_i = size; bus.addr_r_valid_i = 1'b1;
    t = 0;
    #1;
    while (!bus.addr_r_ready_o && t < BUDGET) begin @(negedge clock); #1; t++; end
    if (!bus.addr_r_ready_o) begin
      note_fail({name, "_ar"}, "timed out waiting for addr_r_ready_o");
      bus.addr_r_valid_i = 1'b0;
      if (rq.size() > 0) void'(rq.pop_front());
      return;
    end
    @(posedge clock);
    @(negedge clock);
    bus.addr_r_valid_i = 1'b0;
    #1;
    lat = 0;
    while (!bus.r_valid_o && lat < BUDGET) begin @(posedge clock); lat++; @(negedge clock); #1; end
    check({name, "_rlat"}, 32'(lat), 32'(RD_LAT + 1));
    if (!bus.r_valid_o) return;
    if (rq.size() == 0) begin note_fail(name, "read data with empty scoreboard"); return; end
    e = rq.pop_front();
    check({name, "_rdata"}, bus.r_data_o, e.data);
    check({name, "_rresp"}, 32'(bus.r_resp_o), 32'(e.resp));
    @(posedge clock);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data,
                          input logic [3:0] strb, input string name);
    bit aw_pend, w_pend, aw_hs, w_hs;
    int t;
    int lat;
    logic [1:0] er;
    @(negedge clock);
    bus.addr_w_addr_i = addr; bus.addr_w_size_i = size; bus.addr_w_valid_i = 1'b1;
    bus.w_data_i = data; bus.w_strb_i = strb; bus.w_valid_i = 1'b1;
    aw_pend = 1'b1; w_pend = 1'b1; t = 0;
    while ((aw_pend || w_pend) && t < BUDGET) begin
      #1;
      aw_hs = bus.addr_w_valid_i && bus.addr_w_ready_o;
      w_hs  = bus.w_valid_i && bus.w_ready_o;
      @(posedge clock);
      @(negedge clock);
      t++;
      if (aw_hs) begin bus.addr_w_valid_i = 1'b0; aw_pend = 1'b0; end
      if (w_hs)  begin bus.w_valid_i = 1'b0; w_pend = 1'b0; end
    end
    if (aw_pend || w_pend) begin
      note_fail({name, "_aw_w"}, "timed out waiting for write handshakes");
      bus.addr_w_valid_i = 1'b0; bus.w_valid_i = 1'b0;
      if (bq.size() > 0) void'(bq.pop_front());
      return;
    end
    #1;
    lat = 0;
    while (!bus.bkwd_valid_o && lat < BUDGET) begin @(posedge clock); lat++; @(negedge clock); #1; end
    check({name, "_blat"}, 32'(lat), 32'(WR_LAT + 1));
    if (!bus.bkwd_valid_o) return;
    if (bq.size() == 0) begin note_fail(name, "write response with empty scoreboard"); return; end
    er = bq.pop_front();
    check({name, "_bresp"}, 32'(bus.bkwd_resp_o), 32'(er));
    @(posedge clock);
  endtask

  task automatic wait_any_ready(input string name);
    int t;
    t = 0;
    @(negedge clock);
    #1;
    while (!(bus.addr_r_ready_o || bus.addr_w_ready_o || bus.w_ready_o) && t < BUDGET) begin
      @(negedge clock); #1; t++;
    end
    if (t >= BUDGET) note_fail(name, "timed out waiting for a grant");
  endtask

  task automatic wait_r_valid(input string name);
    int t;
    t = 0;
    #1;
    while (!bus.r_valid_o && t < BUDGET) begin @(negedge clock); #1; t++; end
    if (!bus.r_valid_o) note_fail(name, "timed out waiting for r_valid_o");
  endtask

  initial begin
    rexp_t e;
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;
    check("rst_ar_rdy", 32'(bus.addr_r_ready_o), 32'd0);
    check("rst_aw_rdy", 32'(bus.addr_w_ready_o), 32'd0);
    check("rst_w_rdy",  32'(bus.w_ready_o), 32'd0);
    check("rst_rvalid", 32'(bus.r_valid_o), 32'd0);
    check("rst_bvalid", 32'(bus.bkwd_valid_o), 32'd0);
    check("rst_rdata",  bus.r_data_o, 32'd0);
    check("rst_rresp",  32'(bus.r_resp_o), 32'd0);
    check("rst_bresp",  32'(bus.bkwd_resp_o), 32'd0);
    reset = 1'b0;

    vecs[0]  = '{1'b1, 32'h8000_0010, 3'd2, 32'hDEAD_BEEF, 4'hF, 32'h0,         2'b00};
    vecs[1]  = '{1'b0, 32'h8000_0010, 3'd2, 32'h0,         4'h0, 32'hDEAD_BEEF, 2'b00};
    vecs[2]  = '{1'b1, 32'h8000_0020, 3'd2, 32'h1122_3344, 4'hF, 32'h0,         2'b00};
    vecs[3]  = '{1'b1, 32'h8000_0020, 3'd2, 32'h00AA_0000, 4'h4, 32'h0,         2'b00};
    vecs[4]  = '{1'b0, 32'h8000_0020, 3'd2, 32'h0,         4'h0, 32'h11AA_3344, 2'b00};
    vecs[5]  = '{1'b0, 32'h7FFF_FFFC, 3'd2, 32'h0,         4'h0, 32'h0,         2'b10};
    vecs[6]  = '{1'b1, 32'h8000_0000, 3'd2, 32'h5555_5555, 4'hF, 32'h0,         2'b00};
    vecs[7]  = '{1'b1, 32'h8000_1000, 3'd2, 32'hCAFE_F00D, 4'hF, 32'h0,         2'b10};
    vecs[8]  = '{1'b0, 32'h8000_0000, 3'd2, 32'h0,         4'h0, 32'h5555_5555, 2'b00};
    vecs[9]  = '{1'b1, 32'h8000_0FFC, 3'd2, 32'h0102_0304, 4'hF, 32'h0,         2'b00};
    vecs[10] = '{1'b0, 32'h8000_0FFC, 3'd2, 32'h0,         4'h0, 32'h0102_0304, 2'b00};
    vecs[11] = '{1'b1, 32'h8000_0010, 3'd2, 32'hFFFF_FFFF, 4'h0, 32'h0,         2'b00};
    vecs[12] = '{1'b0, 32'h8000_0010, 3'd2, 32'h0,         4'h0, 32'hDEAD_BEEF, 2'b00};
    vecs[13] = '{1'b0, 32'h8000_0010, 3'd3, 32'h0,         4'h0, 32'h0,         2'b10};
    vecs[14] = '{1'b0, 32'h8000_0013, 3'd0, 32'h0,         4'h0, 32'hDEAD_BEEF, 2'b00};
    vecs[15] = '{1'b1, 32'h8000_0020, 3'd3, 32'hFFFF_FFFF, 4'hF, 32'h0,         2'b10};
    vecs[16] = '{1'b0, 32'h8000_0020, 3'd2, 32'h0,         4'h0, 32'h11AA_3344, 2'b00};
    vecs[17] = '{1'b0, 32'h8000_1000, 3'd2, 32'h0,         4'h0, 32'h0,         2'b10};

    for (int i = 0; i < NVEC; i++) begin
      if (vecs[i].wr) begin
        bq.push_back(vecs[i].exp_resp);
        do_write(vecs[i].addr, vecs[i].size, vecs[i].data, vecs[i].strb, $sformatf("vec%0d", i));
      end else begin
        e.data = vecs[i].exp_data;
        e.resp = vecs[i].exp_resp;
        rq.push_back(e);
        do_read(vecs[i].addr, vecs[i].size, $sformatf("vec%0d", i));
      end
    end

    // Contested grants straight out of reset: read, then write, then read.
    do_reset();
    @(negedge clock);
    bus.addr_r_addr_i = 32'h8000_0010; bus.addr_r_valid_i = 1'b1;
    bus.addr_w_addr_i = 32'h8000_0030; bus.addr_w_valid_i = 1'b1;
    bus.w_data_i = 32'h0BAD_F00D; bus.w_strb_i = 4'hF; bus.w_valid_i = 1'b1;
    #1;
    check("arb1_ar_rdy", 32'(bus.addr_r_ready_o), 32'd1);
    check("arb1_aw_rdy", 32'(bus.addr_w_ready_o), 32'd0);
    check("arb1_w_rdy",  32'(bus.w_ready_o), 32'd0);
    @(posedge clock);
    wait_any_ready("arb2");
    check("arb2_ar_rdy", 32'(bus.addr_r_ready_o), 32'd0);
    check("arb2_aw_rdy", 32'(bus.addr_w_ready_o), 32'd1);
    check("arb2_w_rdy",  32'(bus.w_ready_o), 32'd1);
    @(posedge clock);
    wait_any_ready("arb3");
    check("arb3_ar_rdy", 32'(bus.addr_r_ready_o), 32'd1);
    check("arb3_aw_rdy", 32'(bus.addr_w_ready_o), 32'd0);
    @(posedge clock);
    @(negedge clock);
    idle_inputs();
    wait_r_valid("arb3_r");
    check("arb3_rdata", bus.r_data_o, 32'hDEAD_BEEF);
    @(posedge clock);
    e.data = 32'h0BAD_F00D; e.resp = 2'b00; rq.push_back(e);
    do_read(32'h8000_0030, 3'd2, "arb_wdata");

    // Master stalls R for five cycles while another AR is pending.
    @(negedge clock);
    bus.r_ready_i = 1'b0;
    bus.addr_r_addr_i = 32'h8000_0020; bus.addr_r_valid_i = 1'b1;
    #1;
    check("stall_ar_rdy", 32'(bus.addr_r_ready_o), 32'd1);
    @(posedge clock);
    @(negedge clock);
    wait_r_valid("stall_r");
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall%0d_rvalid", i), 32'(bus.r_valid_o), 32'd1);
      check($sformatf("stall%0d_rdata", i), bus.r_data_o, 32'h11AA_3344);
      check($sformatf("stall%0d_rresp", i), 32'(bus.r_resp_o), 32'd0);
      check($sformatf("stall%0d_ar_rdy", i), 32'(bus.addr_r_ready_o), 32'd0);
      @(negedge clock);
      #1;
    end
    bus.r_ready_i = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.addr_r_valid_i = 1'b0;
    #1;
    check("stall_done_rvalid", 32'(bus.r_valid_o), 32'd0);

    // W arrives alone; AW follows three cycles later.
    @(negedge clock);
    bus.w_data_i = 32'h7766_5544; bus.w_strb_i = 4'hF; bus.w_valid_i = 1'b1;
    bus.addr_w_addr_i = 32'h8000_0040; bus.addr_w_size_i = 3'd2;
    #1;
    check("wfirst_w_rdy", 32'(bus.w_ready_o), 32'd1);
    @(posedge clock);
    @(negedge clock);
    bus.w_valid_i = 1'b0;
    for (int i = 1; i < 3; i++) begin
      #1;
      check($sformatf("wfirst_c%0d_w_rdy", i), 32'(bus.w_ready_o), 32'd0);
      check($sformatf("wfirst_c%0d_aw_rdy", i), 32'(bus.addr_w_ready_o), 32'd1);
      check($sformatf("wfirst_c%0d_bvalid", i), 32'(bus.bkwd_valid_o), 32'd0);
      @(negedge clock);
    end
    bus.addr_w_valid_i = 1'b1;
    #1;
    check("wfirst_aw_rdy", 32'(bus.addr_w_ready_o), 32'd1);
    @(posedge clock);
    @(negedge clock);
    bus.addr_w_valid_i = 1'b0;
    begin
      int lat;
      lat = 0;
      #1;
      while (!bus.bkwd_valid_o && lat < BUDGET) begin @(posedge clock); lat++; @(negedge clock); #1; end
      check("wfirst_blat", 32'(lat), 32'(WR_LAT + 1));
      check("wfirst_bresp", 32'(bus.bkwd_resp_o), 32'd0);
      @(posedge clock);
    end
    e.data = 32'h7766_5544; e.resp = 2'b00; rq.push_back(e);
    do_read(32'h8000_0040, 3'd2, "wfirst_rd");

    // Reset lands in the commit cycle of a write: memory must keep the old word.
    bq.push_back(2'b00);
    do_write(32'h8000_0050, 3'd2, 32'h1234_5678, 4'hF, "pre_abort");
    @(negedge clock);
    bus.addr_w_addr_i = 32'h8000_0050; bus.addr_w_valid_i = 1'b1;
    bus.w_data_i = 32'hFFFF_FFFF; bus.w_strb_i = 4'hF; bus.w_valid_i = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.addr_w_valid_i = 1'b0; bus.w_valid_i = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    #1;
    check("abort_bvalid", 32'(bus.bkwd_valid_o), 32'd0);
    check("abort_bresp", 32'(bus.bkwd_resp_o), 32'd0);
    reset = 1'b0;
    e.data = 32'h1234_5678; e.resp = 2'b00; rq.push_back(e);
    do_read(32'h8000_0050, 3'd2, "abort_rd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
